// File: rtl/clk_div_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// clk_div_sched : start/stop/drain sequencer for a counter clock divider with
// boundary-applied config. Optional macro TICK_CNT_EN adds a tick counter.
// Revision: 1.0
// ----------------------------------------------------------------------------
module clk_div_sched #(
  parameter int CNT_W      = 26,
  parameter int DEF_PERIOD = 50000000,
  parameter int DEF_HIGH   = 25000000
) (
  input  logic             clk_50mHz,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic             cfg_err
`ifdef TICK_CNT_EN
  ,
  output logic [15:0]      tick_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_zero       = '0;
  localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_two        = CNT_W'(2);
  localparam logic [CNT_W-1:0] c_def_period = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] c_def_high   = CNT_W'(DEF_HIGH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic [CNT_W-1:0] r_pend_period;
  logic [CNT_W-1:0] r_pend_high;
  logic             r_pend_vld;
  logic             r_clk_out;
  logic             r_tick;
  logic             r_cfg_err;

  logic w_running;
  logic w_boundary;
  logic w_cfg_ok;
  logic w_cfg_take;
  logic w_apply;

  assign w_running  = (r_state != S_IDLE);
  assign w_boundary = w_running && (r_cnt == (r_period - c_one));
  assign w_cfg_ok   = (cfg_period >= c_two) && (cfg_high != c_zero) && (cfg_high < cfg_period);
  assign w_cfg_take = cfg_valid && !r_pend_vld;
  // Pending values only land when no period is in flight or exactly at its end.
  assign w_apply    = r_pend_vld && ((r_state == S_IDLE) || w_boundary);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (stop) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (start && !stop)  w_state_nxt = S_RUN;
        else if (w_boundary) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50mHz or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_50mHz or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= c_zero;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      if (!w_running || w_boundary) r_cnt <= c_zero;
      else                          r_cnt <= r_cnt + c_one;
      r_clk_out <= w_running && (r_cnt < r_high);
      r_tick    <= w_boundary;
      r_cfg_err <= w_cfg_take && !w_cfg_ok;
    end
  end

  always_ff @(posedge clk_50mHz or negedge rst_n) begin
    if (!rst_n) begin
      r_period      <= c_def_period;
      r_high        <= c_def_high;
      r_pend_period <= c_zero;
      r_pend_high   <= c_zero;
      r_pend_vld    <= 1'b0;
    end else if (w_apply) begin
      r_period   <= r_pend_period;
      r_high     <= r_pend_high;
      r_pend_vld <= 1'b0;
    end else if (w_cfg_take && w_cfg_ok) begin
      r_pend_period <= cfg_period;
      r_pend_high   <= cfg_high;
      r_pend_vld    <= 1'b1;
    end
  end

`ifdef TICK_CNT_EN
  logic [15:0] r_tick_cnt;

  // Restarting from IDLE begins a fresh count; resuming out of DRAIN keeps it.
  always_ff @(posedge clk_50mHz or negedge rst_n) begin
    if (!rst_n)                         r_tick_cnt <= 16'd0;
    else if ((r_state == S_IDLE) && start) r_tick_cnt <= 16'd0;
    else if (w_boundary)                r_tick_cnt <= r_tick_cnt + 16'd1;
  end

  assign tick_cnt = r_tick_cnt;
`endif

  assign clk_out   = r_clk_out;
  assign tick      = r_tick;
  assign busy      = w_running;
  assign cfg_ready = !r_pend_vld;
  assign cfg_err   = r_cfg_err;

endmodule
`default_nettype wire

// File: doc/clk_div_sched.md
Name: clk_div_sched

Overview:
- Run-time controller for the board's counter-based clock divider.
- Sequences start, stop and drain of the divided output, and holds the divide ratio and high-phase length.
- Accepts new ratios over a valid/ready handshake and applies them only at a period boundary, so the output never glitches.
- Sits between the 50 MHz board clock and slow consumers (display scan, 1 Hz timers).

Parameters:
CNT_W, 26, width of counter and config fields
DEF_PERIOD, 50000000, period in clk cycles after reset
DEF_HIGH, 25000000, high-phase cycles after reset

Ports:
clk_50mHz  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse, begin or continue running
stop  input  1  one-cycle pulse, stop at end of current period
cfg_valid  input  1  config offered
cfg_ready  output  1  config slot free
cfg_period  input  CNT_W  requested period in cycles
cfg_high  input  CNT_W  requested high-phase cycles
clk_out  output  1  divided clock, registered
tick  output  1  one-cycle pulse in last cycle of each period
busy  output  1  state != IDLE
cfg_err  output  1  one-cycle pulse, config rejected

Behaviour:
- Reset (async, rst_n=0) clears everything immediately, including mid-period and any pending config:
  - state=IDLE, cnt=0
  - period_r=DEF_PERIOD, high_r=DEF_HIGH
  - pend_vld=0, clk_out=0, tick=0, busy=0, cfg_ready=1, cfg_err=0
- States IDLE, RUN, DRAIN:
  - IDLE --start--> RUN, with cnt=0.
  - RUN --stop--> DRAIN. start in RUN is ignored.
  - DRAIN --start (without stop)--> RUN, continuous, with no break in the waveform.
  - DRAIN --end of period--> IDLE.
  - start and stop in the same cycle:
    - IDLE: enters RUN.
    - RUN: enters DRAIN.
    - DRAIN: stays in DRAIN.
- Counter (RUN/DRAIN):
  - cnt steps 0..period_r-1, then wraps to 0.
  - Boundary cycle is cnt==period_r-1.
- Outputs:
  - clk_out <= (cnt<high_r) && running. It is high for high_r cycles, then low for period_r-high_r cycles.
  - Latency: first clk_out=1 appears one edge after the edge that samples start.
  - tick <= running && cnt==period_r-1. It is coincident with the last low cycle.
  - In IDLE, clk_out=0 and tick=0.
  - DRAIN->IDLE: the final period completes fully, including its tick. clk_out is 0 from the next cycle.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready.
  - A config is valid only if period>=2, high>=1 and high<period.
  - Valid config: latched into pend_period/pend_high, pend_vld=1, cfg_ready=0.
  - Invalid config: discarded, cfg_err=1 for the following cycle, cfg_ready stays 1.
- Applying a pending config:
  - In IDLE it applies on the next edge.
  - In RUN/DRAIN it applies on the boundary edge, so the next period uses the new values. This includes the final DRAIN boundary.
  - When applied: pend_vld=0 and cfg_ready=1 on the same edge.
- Widths: all compares are unsigned CNT_W. No overflow is possible since cnt<period_r<=2^CNT_W-1.

Optional Feature:
- Macro TICK_CNT_EN.
- Defined:
  - Adds output tick_cnt [15:0], incremented on each tick, wrapping 65535->0.
  - Cleared by reset and on the IDLE->RUN transition.
  - Not cleared on DRAIN->RUN.
- Undefined: port and counter absent. All other behaviour is identical.

Test Plan:
- Reset with DEF_PERIOD=10, DEF_HIGH=5, then start pulse -> clk_out 1 for 5 cycles, 0 for 5 cycles, repeating; tick every 10th cycle; busy=1.
- IDLE, cfg period=4 high=1, then start -> cfg_ready low 1 cycle; waveform 1,0,0,0 repeating; tick on 4th cycle.
- RUN period=10 high=5, cfg period=4 high=2 mid-period -> current 10-cycle period completes, then 1,1,0,0 pattern; cfg_ready returns 1 at that boundary.
- cfg period=3 high=3, and separately period=1 high=0 -> each gives cfg_err one-cycle pulse; active config unchanged; cfg_ready stays 1.
- RUN, stop at cnt=2 of period 10 -> busy stays 1 until boundary; last tick seen; then clk_out=0, busy=0. Repeat with start during DRAIN -> no gap in waveform.
- rst_n low mid-RUN with pending config -> outputs clear asynchronously; after release DEF values are active and no pending config is applied. With TICK_CNT_EN, tick_cnt=0 after 3 periods and a reset, and 3 after 3 periods without reset.
